// File: rtl/timer_ctrl_if.sv
// Button/zero-flag inputs and tick/load/status outputs between the timer
// control stage and its environment (buttons and digit chain).
interface timer_ctrl_if;
  logic START;
  logic CLEAR;
  logic ZERO;
  logic EN;
  logic LOAD;
  logic RUNNING;
  logic BUZZ;

  modport master (output START, CLEAR, ZERO, input EN, LOAD, RUNNING, BUZZ);
  modport slave  (input START, CLEAR, ZERO, output EN, LOAD, RUNNING, BUZZ);
endinterface

// File: rtl/timer_ctrl.sv
// Prescaler and START/CLEAR control FSM feeding the countdown digit chain.
// Emits one-cycle count ticks, preset loads, and a bounded alarm on timeout.
module timer_ctrl #(
  parameter int PRESCALE   = 4,
  parameter int BUZZ_TICKS = 3
) (
  input logic         CLOCK,
  input logic         RESET_N,
  timer_ctrl_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(BUZZ_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   buzz_cnt_q, buzz_cnt_d;
  logic            start_d_q, clear_d_q;
  logic            en_q, en_d;
  logic            load_q, load_d;
  logic            running_q, running_d;
  logic            buzz_q, buzz_d;

  logic            start_rise, clear_rise, tick;
  logic [PW-1:0]   presc_nxt;

  always_comb begin
    start_rise = bus.START & ~start_d_q;
    clear_rise = bus.CLEAR & ~clear_d_q;
    tick       = (presc_q == PW'(PRESCALE - 1));
    presc_nxt  = tick ? '0 : presc_q + PW'(1);

    state_d    = state_q;
    presc_d    = presc_q;
    buzz_cnt_d = buzz_cnt_q;
    en_d       = 1'b0;
    load_d     = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d    = '0;
        buzz_cnt_d = '0;
        if (clear_rise)
          load_d = 1'b1;
        else if (start_rise && !bus.ZERO)
          state_d = RUN;
      end
      RUN: begin
        if (clear_rise) begin
          state_d = IDLE;
          load_d  = 1'b1;
          presc_d = '0;
        end else if (bus.ZERO) begin
          // EN is gated here so the chain never wraps past all-zero
          state_d = ALARM;
          presc_d = '0;
        end else if (start_rise) begin
          // Hold the prescaler so a pending tick is issued after resume
          state_d = PAUSE;
        end else begin
          presc_d = presc_nxt;
          en_d    = tick;
        end
      end
      PAUSE: begin
        if (clear_rise) begin
          state_d = IDLE;
          load_d  = 1'b1;
          presc_d = '0;
        end else if (start_rise) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (clear_rise || start_rise) begin
          state_d    = IDLE;
          load_d     = clear_rise;
          presc_d    = '0;
          buzz_cnt_d = '0;
        end else begin
          presc_d = presc_nxt;
          if (tick) begin
            if (buzz_cnt_q == BW'(BUZZ_TICKS - 1)) begin
              state_d    = IDLE;
              presc_d    = '0;
              buzz_cnt_d = '0;
            end else begin
              buzz_cnt_d = buzz_cnt_q + BW'(1);
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        presc_d    = '0;
        buzz_cnt_d = '0;
      end
    endcase

    running_d = (state_d == RUN);
    buzz_d    = (state_d == ALARM);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      buzz_cnt_q <= '0;
      start_d_q  <= 1'b0;
      clear_d_q  <= 1'b0;
      en_q       <= 1'b0;
      load_q     <= 1'b0;
      running_q  <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      buzz_cnt_q <= buzz_cnt_d;
      start_d_q  <= bus.START;
      clear_d_q  <= bus.CLEAR;
      en_q       <= en_d;
      load_q     <= load_d;
      running_q  <= running_d;
      buzz_q     <= buzz_d;
    end
  end

  assign bus.EN      = en_q;
  assign bus.LOAD    = load_q;
  assign bus.RUNNING = running_q;
  assign bus.BUZZ    = buzz_q;
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control and prescaler stage directly upstream of the countdown digit chain.
- Divides CLOCK down to a one-cycle count-enable tick (EN) and drives it into the lowest seconds digit; that digit's BO cascades into the modulo-6 tens-of-seconds down counter.
- Runs a START/CLEAR state machine that preloads, runs, pauses and stops the chain.
- Consumes the chain's all-digits-zero flag (ZERO) to end the run and sound the alarm for a bounded time.

Parameters:
- PRESCALE, 4, CLOCK cycles per count tick (≥2); 50_000_000 on board, small in simulation.
- BUZZ_TICKS, 3, number of ticks the alarm output stays high after timeout (≥1).

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  start/pause button, already synchronised level; acts on rising edge only.
- CLEAR  input  1  clear button, synchronised level; acts on rising edge only.
- ZERO  input  1  high when every digit counter in the chain reads 0.
- EN  output  1  one-cycle count-enable pulse to the lowest digit counter.
- LOAD  output  1  one-cycle pulse commanding digit counters to load the preset.
- RUNNING  output  1  high in RUN state.
- BUZZ  output  1  alarm drive, high in ALARM state.

Behaviour:
- Reset: RESET_N low asynchronously forces state=IDLE, prescaler=0, buzz counter=0, START/CLEAR edge registers=0, EN=LOAD=RUNNING=BUZZ=0. The design clocks normally from the first edge after release.
- Edge detect: START_rise = START & ~START_d and CLEAR_rise = CLEAR & ~CLEAR_d, where the _d registers are updated every cycle. A button held high produces exactly one event.
- Priority: CLEAR_rise beats START_rise when both occur in the same cycle.
- Prescaler: width clog2(PRESCALE), counts 0..PRESCALE-1 only in RUN and ALARM, wraps to 0. tick = (prescaler == PRESCALE-1).
- States:
  - IDLE: prescaler held at 0.
    - CLEAR_rise -> IDLE, LOAD=1 for one cycle.
    - START_rise with ZERO=0 -> RUN, prescaler=0.
    - START_rise with ZERO=1 -> stays IDLE (nothing to count).
  - RUN: RUNNING=1.
    - EN = tick & ~ZERO, registered, so EN is high in the cycle after the prescaler reaches PRESCALE-1 and is a single cycle wide.
    - ZERO=1 sampled -> ALARM next cycle, prescaler=0. No EN is issued in or after the cycle ZERO is seen, so the chain never wraps past 00.
    - START_rise -> PAUSE. CLEAR_rise -> IDLE with LOAD pulse.
  - PAUSE: prescaler frozen at its current value, EN=0.
    - START_rise -> RUN, resuming from the frozen prescaler value (no lost or extra partial tick).
    - CLEAR_rise -> IDLE with LOAD pulse.
  - ALARM: BUZZ=1. Buzz counter increments on each tick.
    - When the counter reaches BUZZ_TICKS-1 and tick occurs -> IDLE, BUZZ=0, buzz counter=0.
    - START_rise or CLEAR_rise -> IDLE immediately. CLEAR additionally pulses LOAD; START does not.
- Outputs: all outputs are registered. LOAD and EN are never high for more than one consecutive cycle.
- Reset asserted mid-RUN or mid-ALARM: outputs drop asynchronously and any pending EN is discarded.
- No illegal-state lockup: unused state encodings return to IDLE.

Test Plan:
- Reset then idle: RESET_N low 3 cycles, release, no buttons -> EN=LOAD=RUNNING=BUZZ=0 for 20 cycles, prescaler stays 0.
- Run: ZERO=0, START pulse -> RUNNING=1 next cycle; EN single-cycle pulses exactly every 4 cycles, first one 4 cycles after entering RUN; holding START high for 10 cycles yields no extra events.
- Pause/resume: START at prescaler=2, pause 10 cycles (no EN), START again -> next EN 2 cycles after resume; total EN count matches uninterrupted run minus paused time.
- Timeout: ZERO rises in RUN -> no further EN, BUZZ=1 next cycle, stays high for 3 ticks (12 cycles), then IDLE with BUZZ=0; START in mid-ALARM ends it at once without LOAD.
- Clear/priority: START and CLEAR rise together in RUN -> IDLE, LOAD=1 for exactly one cycle, RUNNING=0; START while ZERO=1 in IDLE -> stays IDLE.
- Async reset mid-run: drop RESET_N between clock edges during RUN -> RUNNING and EN go 0 immediately without waiting for an edge; after release the block is in IDLE.
